// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer, its program memory and the
// four instruction FSMs (run request, fetch address/data, start/done pulses, status).
interface instr_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic                run;
    logic [PC_WIDTH-1:0] pc_addr;
    logic [14:0]         instr_in;
    logic [5:0]          Ri;
    logic [5:0]          num;
    logic                start_movi;
    logic                start_mov;
    logic                start_add;
    logic                start_sub;
    logic                done_movi;
    logic                done_mov;
    logic                done_add;
    logic                done_sub;
    logic                busy;
    logic                halted;
    logic                error;

    modport master (
        input  run, instr_in, done_movi, done_mov, done_add, done_sub,
        output pc_addr, Ri, num, start_movi, start_mov, start_add, start_sub,
               busy, halted, error
    );

    modport slave (
        output run, instr_in, done_movi, done_mov, done_add, done_sub,
        input  pc_addr, Ri, num, start_movi, start_mov, start_add, start_sub,
               busy, halted, error
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches from a synchronous-read program memory, dispatches
// MOVI/MOV/ADD/SUB to their FSMs and waits for completion under a per-instruction watchdog.
module instr_sequencer #(
    parameter int PC_WIDTH = 8,
    parameter int TIMEOUT  = 15
) (
    input logic               clk,
    input logic               reset,
    instr_sequencer_if.master bus
);
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MOVI = 3'd1;
    localparam logic [2:0] OP_MOV  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [PC_WIDTH-1:0] PC_ONE     = PC_WIDTH'(1);
    localparam logic [7:0]          WDOG_LIMIT = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DISPATCH,
        S_WAIT,
        S_HALT,
        S_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pcNext;
    logic [14:0]         r_ir;
    logic                w_irLoad;
    logic [7:0]          r_wdog;
    logic [7:0]          w_wdogNext;
    logic [7:0]          w_wdogInc;
    logic                r_busy;
    logic                r_halted;
    logic                r_error;
    logic [2:0]          w_op;
    logic                w_done;

    assign w_op      = r_ir[14:12];
    assign w_wdogInc = r_wdog + 8'd1;

    // Only the completion pulse of the unit named by the latched opcode counts.
    always_comb begin
        w_done = 1'b0;
        case (w_op)
            OP_MOVI: w_done = bus.done_movi;
            OP_MOV:  w_done = bus.done_mov;
            OP_ADD:  w_done = bus.done_add;
            OP_SUB:  w_done = bus.done_sub;
            default: w_done = 1'b0;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_pcNext   = r_pc;
        w_irLoad   = 1'b0;
        w_wdogNext = r_wdog;
        case (r_state)
            S_IDLE: begin
                w_pcNext = '0;
                if (bus.run) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next = S_DECODE;
            end
            S_DECODE: begin
                w_irLoad = 1'b1;
                case (bus.instr_in[14:12])
                    OP_NOP: begin
                        w_pcNext = r_pc + PC_ONE;
                        w_next   = S_FETCH;
                    end
                    OP_MOVI, OP_MOV, OP_ADD, OP_SUB: w_next = S_DISPATCH;
                    OP_HALT: w_next = S_HALT;
                    default: w_next = S_ERROR;
                endcase
            end
            S_DISPATCH: begin
                w_wdogNext = '0;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                // A done in the same cycle as the watchdog limit still completes the instruction.
                if (w_done) begin
                    w_pcNext = r_pc + PC_ONE;
                    w_next   = S_FETCH;
                end else begin
                    w_wdogNext = w_wdogInc;
                    if (w_wdogInc == WDOG_LIMIT) begin
                        w_next = S_ERROR;
                    end
                end
            end
            S_HALT: begin
                if (bus.run) begin
                    w_pcNext = '0;
                    w_next   = S_FETCH;
                end
            end
            S_ERROR: begin
                w_next = S_ERROR;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_wdog   <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_pc     <= w_pcNext;
            r_wdog   <= w_wdogNext;
            r_busy   <= (w_next != S_IDLE) && (w_next != S_HALT) && (w_next != S_ERROR);
            r_halted <= (w_next == S_HALT);
            r_error  <= (w_next == S_ERROR);
            if (w_irLoad) begin
                r_ir <= bus.instr_in;
            end
        end
    end

    // Starts decode straight from the state register so reset kills them asynchronously.
    assign bus.start_movi = (r_state == S_DISPATCH) && (w_op == OP_MOVI);
    assign bus.start_mov  = (r_state == S_DISPATCH) && (w_op == OP_MOV);
    assign bus.start_add  = (r_state == S_DISPATCH) && (w_op == OP_ADD);
    assign bus.start_sub  = (r_state == S_DISPATCH) && (w_op == OP_SUB);

    assign bus.pc_addr = r_pc;
    assign bus.Ri      = r_ir[11:6];
    assign bus.num     = r_ir[5:0];
    assign bus.busy    = r_busy;
    assign bus.halted  = r_halted;
    assign bus.error   = r_error;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: an instruction-level timeline model predicts every output per cycle
// for random programs and completion latencies; directed literals pin the model itself.
module tb_instr_sequencer;
    localparam int PCW  = 3;
    localparam int TO   = 4;
    localparam int MAXC = 256;
    localparam logic [PCW-1:0] PONE = PCW'(1);

    logic clk = 1'b0;
    logic reset;

    instr_sequencer_if #(.PC_WIDTH(PCW)) bus();

    instr_sequencer #(.PC_WIDTH(PCW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [14:0] mem [8];

    // Synchronous-read program memory: data appears the cycle after the address.
    always @(posedge clk) bus.instr_in <= mem[bus.pc_addr];

    logic [3:0]     expStart  [MAXC];
    logic           expBusy   [MAXC];
    logic           expHalted [MAXC];
    logic           expError  [MAXC];
    logic [PCW-1:0] expPc     [MAXC];
    logic [5:0]     expRi     [MAXC];
    logic [5:0]     expNum    [MAXC];
    logic           runDrv    [MAXC];
    logic [3:0]     doneDrv   [MAXC];
    int             lat       [64];
    int             nCyc;

    int total = 0;
    int bad   = 0;
    int curCycle = 0;
    int directedId = 0;
    bit cmpEn = 1'b0;

    logic [3:0] startVec;
    assign startVec = {bus.start_sub, bus.start_add, bus.start_mov, bus.start_movi};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] genWord();
        int r;
        logic [2:0] op;
        r = $urandom_range(0, 99);
        if (r < 12)      op = 3'd0;
        else if (r < 82) op = 3'($urandom_range(1, 4));
        else if (r < 94) op = 3'd7;
        else             op = 3'($urandom_range(5, 6));
        return {op, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
    endfunction

    task automatic setCyc(input int c, input logic [3:0] st, input logic b, input logic h,
                          input logic e, input logic [PCW-1:0] p, input logic [5:0] ri,
                          input logic [5:0] nm);
        expStart[c]  = st;
        expBusy[c]   = b;
        expHalted[c] = h;
        expError[c]  = e;
        expPc[c]     = p;
        expRi[c]     = ri;
        expNum[c]    = nm;
    endtask

    // Timeline model: each instruction costs FETCH+DECODE, then either loops (NOP),
    // parks (HALT/illegal) or dispatches and waits L cycles for its done.
    task automatic buildSchedule(input bit allowRestart);
        int t, k, L, h, waitLen;
        bit restarted;
        logic [PCW-1:0] pcm;
        logic [5:0] ri, nm;
        logic [14:0] w;
        logic [2:0] op;
        logic [3:0] sel;
        for (int c = 0; c < MAXC; c++) begin
            setCyc(c, 4'd0, 1'b0, 1'b0, 1'b0, '0, 6'd0, 6'd0);
            runDrv[c]  = 1'b0;
            doneDrv[c] = 4'd0;
        end
        pcm = '0; ri = 6'd0; nm = 6'd0; t = 0; k = 0; restarted = 1'b0;
        runDrv[0]  = 1'b1;
        doneDrv[0] = 4'($urandom_range(0, 15));
        nCyc = 1;
        while (1) begin
            if (t + 30 >= MAXC) begin
                nCyc = t + 1;
                break;
            end
            for (int c = t + 1; c <= t + 2; c++) begin
                setCyc(c, 4'd0, 1'b1, 1'b0, 1'b0, pcm, ri, nm);
                doneDrv[c] = 4'($urandom_range(0, 15));
                runDrv[c]  = 1'($urandom_range(0, 1));
            end
            w = mem[pcm];
            op = w[14:12]; ri = w[11:6]; nm = w[5:0];
            if (op == 3'd0) begin
                pcm = pcm + PONE;
                t = t + 2;
            end else if (op <= 3'd4) begin
                sel = 4'b0001 << (op - 3'd1);
                setCyc(t + 3, sel, 1'b1, 1'b0, 1'b0, pcm, ri, nm);
                doneDrv[t + 3] = 4'($urandom_range(0, 15));
                runDrv[t + 3]  = 1'($urandom_range(0, 1));
                L = lat[k];
                k++;
                waitLen = (L <= TO) ? L : TO;
                for (int i = 1; i <= waitLen; i++) begin
                    setCyc(t + 3 + i, 4'd0, 1'b1, 1'b0, 1'b0, pcm, ri, nm);
                    doneDrv[t + 3 + i] = 4'($urandom_range(0, 15)) & ~sel;
                    runDrv[t + 3 + i]  = 1'($urandom_range(0, 1));
                end
                if (L <= TO) begin
                    doneDrv[t + 3 + L] = doneDrv[t + 3 + L] | sel;
                    pcm = pcm + PONE;
                    t = t + 3 + L;
                end else begin
                    for (int c = t + 4 + TO; c < t + 24 + TO; c++) begin
                        setCyc(c, 4'd0, 1'b0, 1'b0, 1'b1, pcm, ri, nm);
                        doneDrv[c] = 4'($urandom_range(0, 15));
                        runDrv[c]  = 1'($urandom_range(0, 1));
                    end
                    nCyc = t + 24 + TO;
                    break;
                end
            end else if (op == 3'd7) begin
                if (allowRestart && !restarted) begin
                    h = t + 3 + $urandom_range(0, 3);
                    for (int c = t + 3; c <= h; c++) begin
                        setCyc(c, 4'd0, 1'b0, 1'b1, 1'b0, pcm, ri, nm);
                        doneDrv[c] = 4'($urandom_range(0, 15));
                    end
                    runDrv[h] = 1'b1;
                    pcm = '0;
                    t = h;
                    restarted = 1'b1;
                end else begin
                    for (int c = t + 3; c < t + 23; c++) begin
                        setCyc(c, 4'd0, 1'b0, 1'b1, 1'b0, pcm, ri, nm);
                        doneDrv[c] = 4'($urandom_range(0, 15));
                    end
                    nCyc = t + 23;
                    break;
                end
            end else begin
                for (int c = t + 3; c < t + 23; c++) begin
                    setCyc(c, 4'd0, 1'b0, 1'b0, 1'b1, pcm, ri, nm);
                    doneDrv[c] = 4'($urandom_range(0, 15));
                    runDrv[c]  = 1'($urandom_range(0, 1));
                end
                nCyc = t + 23;
                break;
            end
        end
    endtask

    task automatic applyReset();
        cmpEn = 1'b0;
        bus.run = 1'b0;
        {bus.done_sub, bus.done_add, bus.done_mov, bus.done_movi} = 4'd0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pc", 32'(bus.pc_addr), 32'd0);
        checkOutput("rst_ri", 32'(bus.Ri), 32'd0);
        checkOutput("rst_num", 32'(bus.num), 32'd0);
        checkOutput("rst_start", 32'(startVec), 32'd0);
        checkOutput("rst_status", 32'({bus.busy, bus.halted, bus.error}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic applyStimulus(input int id, input bit allowRestart);
        directedId = id;
        applyReset();
        buildSchedule(allowRestart);
        if (id == 2) doneDrv[6] = doneDrv[6] | 4'b1000;
        for (int c = 0; c < nCyc; c++) begin
            @(posedge clk);
            #1;
            curCycle = c;
            bus.run = runDrv[c];
            {bus.done_sub, bus.done_add, bus.done_mov, bus.done_movi} = doneDrv[c];
            cmpEn = 1'b1;
        end
        @(posedge clk);
        #1;
        cmpEn = 1'b0;
        bus.run = 1'b0;
        {bus.done_sub, bus.done_add, bus.done_mov, bus.done_movi} = 4'd0;
    endtask

    // Per-cycle comparison against the model, plus hand-derived literals for directed programs.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput($sformatf("start@%0d", curCycle), 32'(startVec), 32'(expStart[curCycle]));
            checkOutput($sformatf("busy@%0d", curCycle), 32'(bus.busy), 32'(expBusy[curCycle]));
            checkOutput($sformatf("halted@%0d", curCycle), 32'(bus.halted), 32'(expHalted[curCycle]));
            checkOutput($sformatf("error@%0d", curCycle), 32'(bus.error), 32'(expError[curCycle]));
            checkOutput($sformatf("pc@%0d", curCycle), 32'(bus.pc_addr), 32'(expPc[curCycle]));
            checkOutput($sformatf("ri@%0d", curCycle), 32'(bus.Ri), 32'(expRi[curCycle]));
            checkOutput($sformatf("num@%0d", curCycle), 32'(bus.num), 32'(expNum[curCycle]));
            case (directedId)
                1: begin
                    if (curCycle == 3) begin
                        checkOutput("lit1_start", 32'(startVec), 32'h1);
                        checkOutput("lit1_num", 32'(bus.num), 32'd15);
                    end
                    if (curCycle == 4) checkOutput("lit1_start_off", 32'(startVec), 32'h0);
                    if (curCycle == 7) checkOutput("lit1_pc", 32'(bus.pc_addr), 32'd1);
                    if (curCycle == 9) checkOutput("lit1_halt", 32'({bus.halted, bus.busy}), 32'b10);
                end
                2: begin
                    if (curCycle == 5) begin
                        checkOutput("lit2_start", 32'(startVec), 32'h4);
                        checkOutput("lit2_ri", 32'(bus.Ri), 32'd1);
                        checkOutput("lit2_num", 32'(bus.num), 32'd2);
                    end
                    if (curCycle == 8) checkOutput("lit2_pc", 32'(bus.pc_addr), 32'd2);
                end
                3: begin
                    if (curCycle == 3) checkOutput("lit3_err", 32'(bus.error), 32'd1);
                    if (curCycle == 20) checkOutput("lit3_sticky", 32'({bus.error, startVec}), 32'h10);
                end
                4: begin
                    if (curCycle == 7) checkOutput("lit4_noerr", 32'(bus.error), 32'd0);
                    if (curCycle == 8) checkOutput("lit4_err", 32'(bus.error), 32'd1);
                end
                5: if (curCycle == 8) checkOutput("lit5_pc", 32'({bus.error, 3'(bus.pc_addr)}), 32'h1);
                6: begin
                    if (curCycle == 29) checkOutput("lit6_pc7", 32'(bus.pc_addr), 32'd7);
                    if (curCycle == 33) checkOutput("lit6_wrap", 32'(bus.pc_addr), 32'd0);
                end
                default: ;
            endcase
        end
    end

    task automatic resetInFlight();
        directedId = 0;
        for (int i = 0; i < 8; i++) mem[i] = 15'h7000;
        mem[0] = 15'h100F;
        applyReset();
        @(posedge clk); #1; bus.run = 1'b1;
        @(posedge clk); #1; bus.run = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        checkOutput("rif_start_pre", 32'({startVec, bus.busy}), 32'h3);
        reset = 1'b0;
        #1;
        checkOutput("rif_start", 32'(startVec), 32'd0);
        checkOutput("rif_status", 32'({bus.busy, bus.halted, bus.error}), 32'd0);
        checkOutput("rif_fields", 32'({bus.Ri, bus.num, 3'(bus.pc_addr)}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.done_movi = 1'b1;
        @(posedge clk); #1;
        bus.done_movi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rif_late_done", 32'({startVec, bus.busy, 3'(bus.pc_addr)}), 32'd0);
            @(posedge clk); #1;
        end
        bus.run = 1'b1;
        @(posedge clk); #1;
        bus.run = 1'b0;
        checkOutput("rif_restart", 32'({bus.busy, 3'(bus.pc_addr)}), 32'h8);
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 8; i++) mem[i] = genWord();
        for (int i = 0; i < 64; i++) begin
            lat[i] = ($urandom_range(0, 9) < 8) ? $urandom_range(1, TO) : $urandom_range(TO + 1, TO + 2);
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.run = 1'b0;
        {bus.done_sub, bus.done_add, bus.done_mov, bus.done_movi} = 4'd0;

        fillRandom(); mem[0] = 15'h100F; mem[1] = 15'h7000; lat[0] = 3;
        applyStimulus(1, 1'b0);
        fillRandom(); mem[0] = 15'h0000; mem[1] = 15'h3042; mem[2] = 15'h7000; lat[0] = 2;
        applyStimulus(2, 1'b0);
        fillRandom(); mem[0] = 15'h5000;
        applyStimulus(3, 1'b0);
        fillRandom(); mem[0] = 15'h1000; lat[0] = TO + 1;
        applyStimulus(4, 1'b0);
        fillRandom(); mem[0] = 15'h1041; mem[1] = 15'h7000; lat[0] = TO;
        applyStimulus(5, 1'b0);
        fillRandom();
        for (int i = 0; i < 8; i++) mem[i] = 15'h1000 | 15'(i);
        for (int i = 0; i < 64; i++) lat[i] = 1;
        applyStimulus(6, 1'b0);

        resetInFlight();

        for (int s = 0; s < 25; s++) begin
            fillRandom();
            applyStimulus(0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
